shiftreg_299: RTL and testbench

Behavioural model of a 74x299 8-bit universal shift/storage register with common parallel I/O pins, asynchronous clear and serial outputs at both ends. It is the shift-out/shift-in counterpart to our octal flip-flop and latch models. Typical uses are serialising a bus word and shifting it in either direction, or reading a serial stream back onto the tri-state data bus. It sits on the CFT data bus alongside the 574/374 register models, and its I/O pins are driven and sampled like theirs.

---
 rtl/shiftreg_299.sv | 62 ++++++
 tb/tb_shiftreg_299.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_299.sv
// 8-bit universal shift/storage register modelled on the 74x299: hold, shift
// right/left, parallel load from the shared tri-state bus, serial taps at both ends.
`timescale 1ns/1ps
module shiftreg_299 #(
    parameter int delay = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] s,
    input  logic       oe1,
    input  logic       oe2,
    input  logic       dsr,
    input  logic       dsl,
    inout  wire  [7:0] io,
    output logic       q0,
    output logic       q7
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [7:0] r_q;
    logic [7:0] r_d;
    logic       io_en;

    // Propagation delay belongs to the board-level timing annotation; this RTL is zero-delay.
    logic unused_delay;
    assign unused_delay = (delay != 0);

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves r_d unassigned (no latch).
        r_d = r_q;
        case (s)
            MODE_HOLD: r_d = r_q;
            MODE_SHR:  r_d = {r_q[6:0], dsr};
            MODE_SHL:  r_d = {dsl, r_q[7:1]};
            MODE_LOAD: r_d = io;
            default:   r_d = r_q;   // unknown select bits behave as hold
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // Load mode releases the bus so the external driver owns it even with both enables low.
    assign io_en = !oe1 && !oe2 && (s != MODE_LOAD);
    assign io    = io_en ? r_q : 'z;

    assign q0 = r_q[0];
    assign q7 = r_q[7];

endmodule

// File: tb/tb_shiftreg_299.sv
// Directed, table-driven bench for shiftreg_299: vector table for shift/load/hold
// plus hand-written sequences for reset, output-enable and coincident-edge cases.
`timescale 1ns/1ps
module tb_shiftreg_299;

    localparam int DELAY = 20;
    localparam int HALF  = 50;

    logic       clk;
    logic       rst;
    logic [1:0] s;
    logic       oe1;
    logic       oe2;
    logic       dsr;
    logic       dsl;
    logic       q0;
    logic       q7;
    logic       bus_en;
    logic [7:0] bus_data;
    wire  [7:0] io;

    int n_checks = 0;
    int n_pass   = 0;

    assign io = bus_en ? bus_data : 8'bzzzz_zzzz;

    shiftreg_299 #(.delay(DELAY)) dut (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .oe1 (oe1),
        .oe2 (oe2),
        .dsr (dsr),
        .dsl (dsl),
        .io  (io),
        .q0  (q0),
        .q7  (q7)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic       sr;
        logic       sl;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.name = n;
        v.mode = m;
        v.sr   = sr;
        v.sl   = sl;
        v.data = d;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Bus must not carry the register value: undriven reads as z (4-state) or a non-matching value.
    task automatic check_off(input string name, input logic [7:0] reg_val);
        n_checks++;
        if (io !== reg_val) n_pass++;
        else $display("FAIL %s: io=%h still driven with register value %h", name, io, reg_val);
    endtask

    // Register readback through io (enables low, s != 11) and both serial taps.
    task automatic check_r(input string name, input logic [7:0] exp);
        check({name, " io"}, io, exp);
        check({name, " q0"}, {7'b0, q0}, {7'b0, exp[0]});
        check({name, " q7"}, {7'b0, q7}, {7'b0, exp[7]});
    endtask

    // One clock edge with the given mode; bus released and s returned to hold right after the edge.
    task automatic tick(input logic [1:0] mode, input logic sr, input logic sl, input logic [7:0] data);
        @(negedge clk);
        s        = mode;
        dsr      = sr;
        dsl      = sl;
        bus_data = data;
        bus_en   = (mode == 2'b11);
        @(posedge clk);
        #1;
        bus_en = 1'b0;
        s      = 2'b00;
        #DELAY;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        s        = 2'b00;
        oe1      = 1'b0;
        oe2      = 1'b0;
        dsr      = 1'b0;
        dsl      = 1'b0;
        bus_en   = 1'b0;
        bus_data = 8'h00;

        // Reset from an arbitrary power-up state with the clock running.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #10 rst = 1'b0;
        #(DELAY + 1);
        check_r("reset clear", 8'h00);

        // Edges while reset is held must be ignored, even a load of FF.
        @(negedge clk);
        s        = 2'b11;
        bus_data = 8'hFF;
        bus_en   = 1'b1;
        dsr      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus_en = 1'b0;
        s      = 2'b00;
        #(DELAY + 1);
        check_r("edges in reset", 8'h00);
        @(negedge clk);
        rst = 1'b1;
        dsr = 1'b0;

        // Vector table: shift left from reset, shift right walking one, load/hold, mixed.
        add("shl dsl1 #1", 2'b10, 1'b0, 1'b1, 8'h00, 8'h80);
        add("shl dsl1 #2", 2'b10, 1'b0, 1'b1, 8'h00, 8'hC0);
        add("shl dsl1 #3", 2'b10, 1'b0, 1'b1, 8'h00, 8'hE0);
        add("shl dsl0 #1", 2'b10, 1'b1, 1'b0, 8'h00, 8'h70);
        add("shl dsl0 #2", 2'b10, 1'b1, 1'b0, 8'h00, 8'h38);
        add("shl dsl0 #3", 2'b10, 1'b1, 1'b0, 8'h00, 8'h1C);
        add("shl dsl0 #4", 2'b10, 1'b1, 1'b0, 8'h00, 8'h0E);
        add("shl dsl0 #5", 2'b10, 1'b1, 1'b0, 8'h00, 8'h07);
        add("load 01",     2'b11, 1'b1, 1'b1, 8'h01, 8'h01);
        add("shr #1",      2'b01, 1'b0, 1'b1, 8'h00, 8'h02);
        add("shr #2",      2'b01, 1'b0, 1'b1, 8'h00, 8'h04);
        add("shr #3",      2'b01, 1'b0, 1'b1, 8'h00, 8'h08);
        add("shr #4",      2'b01, 1'b0, 1'b1, 8'h00, 8'h10);
        add("shr #5",      2'b01, 1'b0, 1'b1, 8'h00, 8'h20);
        add("shr #6",      2'b01, 1'b0, 1'b1, 8'h00, 8'h40);
        add("shr #7",      2'b01, 1'b0, 1'b1, 8'h00, 8'h80);
        add("shr #8 dsr1", 2'b01, 1'b1, 1'b0, 8'h00, 8'h01);
        add("load A5",     2'b11, 1'b0, 1'b0, 8'hA5, 8'hA5);
        add("hold #1",     2'b00, 1'b1, 1'b1, 8'h00, 8'hA5);
        add("hold #2",     2'b00, 1'b1, 1'b1, 8'h00, 8'hA5);
        add("load 5A",     2'b11, 1'b0, 1'b0, 8'h5A, 8'h5A);
        add("shr 5A dsr1", 2'b01, 1'b1, 1'b0, 8'h00, 8'hB5);
        add("shl B5 dsl0", 2'b10, 1'b1, 1'b0, 8'h00, 8'h5A);
        add("load 3C",     2'b11, 1'b0, 1'b0, 8'h3C, 8'h3C);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].data);
            check_r(vecs[i].name, vecs[i].exp);
        end

        // Output enables and mode 11 tri-state, all combinational (no clock edge in between).
        @(negedge clk);
        oe1 = 1'b1;
        #(DELAY + 1);
        check_off("oe1 high", 8'h3C);
        @(negedge clk);
        oe1 = 1'b0;
        oe2 = 1'b1;
        #(DELAY + 1);
        check_off("oe2 high", 8'h3C);
        @(negedge clk);
        oe2 = 1'b0;
        #(DELAY + 1);
        check("oe both low io", io, 8'h3C);
        @(negedge clk);
        s = 2'b11;
        #(DELAY + 1);
        check_off("mode11 off", 8'h3C);
        bus_data = 8'h5A;
        bus_en   = 1'b1;
        #2;
        check("mode11 bus owner", io, 8'h5A);
        bus_en = 1'b0;
        s      = 2'b00;
        #(DELAY + 1);
        check_r("mode11 no clock keeps r", 8'h3C);

        // Async reset in the middle of a right shift of C3.
        tick(2'b11, 1'b0, 1'b0, 8'hC3);
        check_r("load C3", 8'hC3);
        tick(2'b01, 1'b0, 1'b0, 8'h00);
        check_r("shr C3 #1", 8'h86);
        tick(2'b01, 1'b0, 1'b0, 8'h00);
        check_r("shr C3 #2", 8'h0C);
        @(negedge clk);
        #10 rst = 1'b0;
        #(DELAY + 1);
        check_r("async clear mid-shift", 8'h00);
        s   = 2'b01;
        dsr = 1'b1;
        @(posedge clk);
        // Non-blocking so the release lands after the DUT has seen this edge with rst still low.
        @(posedge clk) rst <= 1'b1;
        #(DELAY + 1);
        check_r("release edge ignored", 8'h00);
        @(posedge clk);
        #(DELAY + 1);
        check_r("first shift after release", 8'h01);
        @(posedge clk);
        #(DELAY + 1);
        check_r("second shift after release", 8'h03);

        // rst falling on the same timestep as a clock edge: clear wins.
        @(posedge clk);
        rst = 1'b0;
        #(DELAY + 1);
        check_r("clear wins at edge", 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #(DELAY + 1);
        check_r("shift from 00 after reset", 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
